// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for the single-cycle RISC-V core.
// It loads program words into instruction memory through a valid/ready port
// and holds the core in reset while idle or loading. A trigger starts a run,
// which is either free-running or advances one instruction per step rising edge.
// The run halts when the core fetches HALT_INSTR or after MAX_CYCLES executed cycles.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   trigger           start a run from IDLE / return to IDLE from HALT
//   step_mode, step   single-step select and step request
//   ld_valid/ld_ready/ld_data/ld_last   program loader handshake
//   instr             instruction currently fetched by the core
//   cpu_rst, cpu_en   core reset and per-cycle advance enable
//   imem_we/imem_waddr/imem_wdata       instruction-memory write port
//   state, halted, timeout, cycle_count status
module cpu_run_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'h0000006F,
  parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic                  step_mode,
  input  logic                  step,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  input  logic [DATA_WIDTH-1:0] instr,
  output logic                  cpu_rst,
  output logic                  cpu_en,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic [1:0]            state,
  output logic                  halted,
  output logic                  timeout,
  output logic [31:0]           cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nx_s;
  logic                  step_q_r;
  logic [ADDR_WIDTH-1:0] wptr_r;
  logic                  cpu_rst_r;
  logic                  imem_we_r;
  logic [ADDR_WIDTH-1:0] imem_waddr_r;
  logic [DATA_WIDTH-1:0] imem_wdata_r;
  logic                  halted_r;
  logic                  timeout_r;
  logic [31:0]           cycle_count_r;

  logic                  ld_ready_s;
  logic                  cpu_en_s;
  logic                  xfer_s;
  logic                  start_s;
  logic                  step_edge_s;
  logic                  cycle_hit_s;
  logic                  halt_cond_s;
  logic [ADDR_WIDTH-1:0] waddr_sel_s;

  // Next-state decode plus the combinational handshake and core-enable outputs.
  always_comb begin
    state_nx_s  = state_r;
    ld_ready_s  = 1'b0;
    cpu_en_s    = 1'b0;
    xfer_s      = 1'b0;
    start_s     = 1'b0;
    waddr_sel_s = wptr_r;
    step_edge_s = step & ~step_q_r;
    cycle_hit_s = (MAX_CYCLES != 32'd0) && (cycle_count_r == MAX_CYCLES);
    // The halt word is detected at fetch, so it is never executed.
    halt_cond_s = (instr == HALT_INSTR) || cycle_hit_s;
    case (state_r)
      ST_IDLE: begin
        ld_ready_s  = 1'b1;
        xfer_s      = ld_valid;
        // A new load always starts at word 0.
        waddr_sel_s = {ADDR_WIDTH{1'b0}};
        if (ld_valid) begin
          if (ld_last) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_LOAD;
          end
        end else if (trigger) begin
          state_nx_s = ST_RUN;
          start_s    = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        ld_ready_s = 1'b1;
        xfer_s     = ld_valid;
        if (ld_valid && ld_last) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        cpu_en_s = (step_mode ? step_edge_s : 1'b1) & ~halt_cond_s;
        if (halt_cond_s) begin
          state_nx_s = ST_HALT;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (trigger) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_HALT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register and all registered outputs, bookkeeping and load pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      step_q_r      <= 1'b0;
      wptr_r        <= {ADDR_WIDTH{1'b0}};
      cpu_rst_r     <= 1'b1;
      imem_we_r     <= 1'b0;
      imem_waddr_r  <= {ADDR_WIDTH{1'b0}};
      imem_wdata_r  <= {DATA_WIDTH{1'b0}};
      halted_r      <= 1'b0;
      timeout_r     <= 1'b0;
      cycle_count_r <= 32'd0;
    end else begin
      state_r   <= state_nx_s;
      step_q_r  <= step;
      // Core stays in reset while idle or loading; HALT keeps core state.
      cpu_rst_r <= (state_nx_s == ST_IDLE) || (state_nx_s == ST_LOAD);
      halted_r  <= (state_nx_s == ST_HALT);
      imem_we_r <= xfer_s;
      if (xfer_s) begin
        imem_waddr_r <= waddr_sel_s;
        imem_wdata_r <= ld_data;
        wptr_r       <= waddr_sel_s + ADDR_WIDTH'(1);
      end
      if (start_s) begin
        cycle_count_r <= 32'd0;
        timeout_r     <= 1'b0;
      end else begin
        if (cpu_en_s && (cycle_count_r != 32'hFFFF_FFFF)) begin
          cycle_count_r <= cycle_count_r + 32'd1;
        end
        if ((state_r == ST_RUN) && cycle_hit_s) begin
          timeout_r <= 1'b1;
        end
      end
    end
  end

  assign ld_ready    = ld_ready_s;
  assign cpu_en      = cpu_en_s;
  assign cpu_rst     = cpu_rst_r;
  assign imem_we     = imem_we_r;
  assign imem_waddr  = imem_waddr_r;
  assign imem_wdata  = imem_wdata_r;
  assign state       = state_r;
  assign halted      = halted_r;
  assign timeout     = timeout_r;
  assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl. Instance A uses default parameters; instance B
// uses ADDR_WIDTH=2 and MAX_CYCLES=10. Each instance is paired with a tiny core
// stand-in (PC plus instruction memory fed by the write port).
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trigger = 1'b0;
  logic step_mode = 1'b0;
  logic step = 1'b0;
  logic ld_valid = 1'b0;
  logic [31:0] ld_data = 32'd0;
  logic ld_last = 1'b0;
  logic sel = 1'b0;

  logic a_trigger, a_step, a_ld_valid, a_ld_ready, a_cpu_rst, a_cpu_en, a_imem_we;
  logic a_halted, a_timeout;
  logic [7:0] a_imem_waddr;
  logic [31:0] a_imem_wdata, a_instr, a_cycle_count;
  logic [1:0] a_state;

  logic b_trigger, b_step, b_ld_valid, b_ld_ready, b_cpu_rst, b_cpu_en, b_imem_we;
  logic b_halted, b_timeout;
  logic [1:0] b_imem_waddr;
  logic [31:0] b_imem_wdata, b_instr, b_cycle_count;
  logic [1:0] b_state;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [4];
  logic [7:0] pc_a = 8'd0;
  logic [1:0] pc_b = 2'd0;

  int tests = 0;
  int failed = 0;
  int en_cnt = 0;

  always #5 clk = ~clk;

  assign a_trigger  = trigger & ~sel;
  assign a_step     = step & ~sel;
  assign a_ld_valid = ld_valid & ~sel;
  assign b_trigger  = trigger & sel;
  assign b_step     = step & sel;
  assign b_ld_valid = ld_valid & sel;

  assign a_instr = mem_a[pc_a];
  assign b_instr = mem_b[pc_b];

  cpu_run_ctrl u_a (
    .clk(clk), .rst(rst), .trigger(a_trigger), .step_mode(step_mode), .step(a_step),
    .ld_valid(a_ld_valid), .ld_ready(a_ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .instr(a_instr), .cpu_rst(a_cpu_rst), .cpu_en(a_cpu_en), .imem_we(a_imem_we),
    .imem_waddr(a_imem_waddr), .imem_wdata(a_imem_wdata), .state(a_state),
    .halted(a_halted), .timeout(a_timeout), .cycle_count(a_cycle_count)
  );

  cpu_run_ctrl #(.ADDR_WIDTH(2), .MAX_CYCLES(32'd10)) u_b (
    .clk(clk), .rst(rst), .trigger(b_trigger), .step_mode(step_mode), .step(b_step),
    .ld_valid(b_ld_valid), .ld_ready(b_ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .instr(b_instr), .cpu_rst(b_cpu_rst), .cpu_en(b_cpu_en), .imem_we(b_imem_we),
    .imem_waddr(b_imem_waddr), .imem_wdata(b_imem_wdata), .state(b_state),
    .halted(b_halted), .timeout(b_timeout), .cycle_count(b_cycle_count)
  );

  // Core stand-ins: instruction memory written by the controller, PC advanced by cpu_en.
  always @(posedge clk) begin
    if (a_imem_we) mem_a[a_imem_waddr] <= a_imem_wdata;
    if (b_imem_we) mem_b[b_imem_waddr] <= b_imem_wdata;
    if (a_cpu_rst) pc_a <= 8'd0;
    else if (a_cpu_en) pc_a <= pc_a + 8'd1;
    if (b_cpu_rst) pc_b <= 2'd0;
    else if (b_cpu_en) pc_b <= pc_b + 2'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One single-step cycle on instance A: drive step, count enables, advance.
  task automatic stp(input logic s);
    step = s;
    #1;
    if (a_cpu_en === 1'b1) en_cnt++;
    tick();
  endtask

  logic [31:0] prog [4];
  logic [31:0] progb [5];

  initial begin
    for (int i = 0; i < 256; i++) mem_a[i] = 32'd0;
    for (int i = 0; i < 4; i++) mem_b[i] = 32'd0;
    prog[0] = 32'h00500093; prog[1] = 32'h00100113;
    prog[2] = 32'h002081B3; prog[3] = 32'h0000006F;
    progb[0] = 32'h11111111; progb[1] = 32'h22222222; progb[2] = 32'h33333333;
    progb[3] = 32'h44444444; progb[4] = 32'h55555555;

    // Reset values
    tick(); tick();
    chk("rst_state", {30'd0, a_state}, 32'd0);
    chk("rst_cpu_rst", {31'd0, a_cpu_rst}, 32'd1);
    chk("rst_cpu_en", {31'd0, a_cpu_en}, 32'd0);
    chk("rst_we", {31'd0, a_imem_we}, 32'd0);
    chk("rst_waddr", {24'd0, a_imem_waddr}, 32'd0);
    chk("rst_wdata", a_imem_wdata, 32'd0);
    chk("rst_halted", {31'd0, a_halted}, 32'd0);
    chk("rst_timeout", {31'd0, a_timeout}, 32'd0);
    chk("rst_count", a_cycle_count, 32'd0);
    chk("rst_b_state", {30'd0, b_state}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", {31'd0, a_ld_ready}, 32'd1);

    // Load 4 words back-to-back into A
    ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_data = prog[i];
      ld_last = (i == 3);
      tick();
      chk("ld_we", {31'd0, a_imem_we}, 32'd1);
      chk("ld_waddr", {24'd0, a_imem_waddr}, i);
      chk("ld_wdata", a_imem_wdata, prog[i]);
      chk("ld_state", {30'd0, a_state}, (i == 3) ? 32'd0 : 32'd1);
      chk("ld_ready", {31'd0, a_ld_ready}, 32'd1);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    chk("ld_we_off", {31'd0, a_imem_we}, 32'd0);

    // Free run until the halt word is fetched
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("run_state", {30'd0, a_state}, 32'd2);
    chk("run_cpu_rst", {31'd0, a_cpu_rst}, 32'd0);
    chk("run_ready", {31'd0, a_ld_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("run_en", {31'd0, a_cpu_en}, 32'd1);
      tick();
    end
    chk("halt_fetch_en", {31'd0, a_cpu_en}, 32'd0);
    chk("halt_fetch_state", {30'd0, a_state}, 32'd2);
    tick();
    chk("halt_state", {30'd0, a_state}, 32'd3);
    chk("halt_halted", {31'd0, a_halted}, 32'd1);
    chk("halt_count", a_cycle_count, 32'd3);
    chk("halt_timeout", {31'd0, a_timeout}, 32'd0);
    chk("halt_cpu_rst", {31'd0, a_cpu_rst}, 32'd0);

    // Back to IDLE, then single-step run
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("ret_idle", {30'd0, a_state}, 32'd0);
    chk("ret_cpu_rst", {31'd0, a_cpu_rst}, 32'd1);
    tick();
    step_mode = 1'b1;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("step_cnt_clr", a_cycle_count, 32'd0);
    for (int i = 0; i < 5; i++) stp(1'b1);
    stp(1'b0);
    stp(1'b1); stp(1'b0);
    stp(1'b1); stp(1'b0);
    stp(1'b0);
    chk("step_en_total", en_cnt, 32'd3);
    chk("step_count", a_cycle_count, 32'd3);
    chk("step_state", {30'd0, a_state}, 32'd3);
    step_mode = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;

    // Single-word load in IDLE wins over trigger and stays IDLE
    ld_valid = 1'b1; ld_last = 1'b1; trigger = 1'b1; ld_data = 32'hDEADBEEF;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0; trigger = 1'b0;
    chk("prio_state", {30'd0, a_state}, 32'd0);
    chk("prio_we", {31'd0, a_imem_we}, 32'd1);
    chk("prio_waddr", {24'd0, a_imem_waddr}, 32'd0);
    chk("prio_wdata", a_imem_wdata, 32'hDEADBEEF);
    tick();

    // Instance B: 5 words into a 4-word memory wrap to address 0
    sel = 1'b1;
    ld_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ld_data = progb[i];
      ld_last = (i == 4);
      tick();
      chk("b_ld_waddr", {30'd0, b_imem_waddr}, i % 4);
      chk("b_ld_wdata", b_imem_wdata, progb[i]);
      chk("b_ld_state", {30'd0, b_state}, (i == 4) ? 32'd0 : 32'd1);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    chk("b_overwrite", mem_b[0], 32'h55555555);

    // Instance B: timeout after 10 executed cycles
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("b_run_en", {31'd0, b_cpu_en}, 32'd1);
      tick();
    end
    chk("b_to_count", b_cycle_count, 32'd10);
    chk("b_to_en", {31'd0, b_cpu_en}, 32'd0);
    tick();
    chk("b_to_state", {30'd0, b_state}, 32'd3);
    chk("b_to_flag", {31'd0, b_timeout}, 32'd1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("b_idle_state", {30'd0, b_state}, 32'd0);
    chk("b_idle_cpu_rst", {31'd0, b_cpu_rst}, 32'd1);
    chk("b_idle_timeout", {31'd0, b_timeout}, 32'd1);
    tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("b_rerun_timeout", {31'd0, b_timeout}, 32'd0);
    chk("b_rerun_count", b_cycle_count, 32'd0);
    tick(); tick(); tick();
    chk("b_mid_count", b_cycle_count, 32'd3);

    // Reset mid-RUN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("b_rrun_state", {30'd0, b_state}, 32'd0);
    chk("b_rrun_cpu_rst", {31'd0, b_cpu_rst}, 32'd1);
    chk("b_rrun_cpu_en", {31'd0, b_cpu_en}, 32'd0);
    chk("b_rrun_count", b_cycle_count, 32'd0);
    chk("b_rrun_halted", {31'd0, b_halted}, 32'd0);
    chk("b_rrun_timeout", {31'd0, b_timeout}, 32'd0);

    // Reset mid-LOAD
    ld_valid = 1'b1; ld_data = 32'h0000AAAA;
    tick();
    ld_data = 32'h0000BBBB;
    tick();
    chk("b_mload_state", {30'd0, b_state}, 32'd1);
    ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("b_rload_state", {30'd0, b_state}, 32'd0);
    chk("b_rload_we", {31'd0, b_imem_we}, 32'd0);
    chk("b_rload_waddr", {30'd0, b_imem_waddr}, 32'd0);
    chk("b_rload_wdata", b_imem_wdata, 32'd0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("b_post_state", {30'd0, b_state}, 32'd2);
    chk("b_post_count0", b_cycle_count, 32'd0);
    tick();
    chk("b_post_count1", b_cycle_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
